trace_uart_streamer: RTL
========================

// Module: trace_uart_streamer
// PURPOSE
//  Reader/drain side of the 512x8 sensor-trace BRAM: on start, reads trace_len bytes from base_addr
//  and streams them to the UART TX as one framed packet: SYNC, LEN_LO, LEN_HI, payload, XOR checksum.
//  Replaces the ad-hoc SEND_SENSE loop in the top-level FSM; that FSM only pulses start and waits done.
// PARAMETERS
//  ADDR_W     9      BRAM read-address width (512 entries)
//  SYNC_BYTE  8'hA5  first byte of every frame
//  RD_LAT     1      BRAM read latency in clk cycles (raddr registered -> rdata valid); legal 1..2
// PORTS
//  clk             in   1         system clock (BRAM read port, UART TX domain)
//  rst             in   1         asynchronous, active-low reset
//  start           in   1         one-cycle request; sampled only in IDLE
//  base_addr       in   ADDR_W    first BRAM address of the trace
//  trace_len       in   ADDR_W+1  payload byte count, 0..512; values >512 clamp to 512
//  raddr           out  ADDR_W    BRAM read address
//  rdata           in   8         BRAM read data (already de-interleaved byte)
//  uart_tx_ready   in   1         UART idle, can accept a byte
//  uart_tx_enable  out  1         one-cycle pulse: uart_data_to_tx is valid, send it
//  uart_data_to_tx out  8         byte to transmit
//  busy            out  1         high from the cycle after accepted start until done
//  done            out  1         one-cycle pulse after checksum byte is issued
// BEHAVIOUR
//  - Reset: all outputs 0, raddr=0, state IDLE, checksum=0, counters=0.
//  - Issue rule: a byte is issued only when uart_tx_ready=1 and uart_tx_enable=0 in the same cycle;
//    uart_tx_enable is high exactly one cycle per byte, never two consecutive cycles.
//  - start in IDLE latches base_addr, clamped trace_len; clears checksum; busy=1 next cycle.
//    start while busy is ignored (no queueing).
//  - FSM: IDLE -> SYNC -> LEN_LO -> LEN_HI -> (len==0 ? CKSUM : FETCH) ;
//    FETCH: drive raddr=base+idx -> WAIT (RD_LAT cycles) -> capture rdata -> SEND ;
//    SEND: issue byte, idx++ -> (idx==len ? CKSUM : FETCH) ; CKSUM: issue checksum -> DONE -> IDLE.
//  - Each issuing state holds until the issue rule is met; data captured in WAIT is held stable.
//  - LEN_LO = len[7:0], LEN_HI = {6'b0, len[9:8]} (zero-extended).
//  - Checksum = XOR of LEN_LO, LEN_HI and all payload bytes; SYNC excluded.
//  - Address arithmetic modulo 2^ADDR_W: base=510, len=4 reads 510,511,0,1.
//  - Frame length = len + 4 bytes; len=0 yields A5,00,00,00.
//  - done pulses in the DONE cycle; busy drops in the same cycle; new start accepted from next cycle.
//  - rst asserted mid-frame: immediate return to IDLE, uart_tx_enable=0 asynchronously; a partial
//    frame is not completed; no spurious enable after release.
//  - raddr holds its last value outside FETCH (no extra BRAM reads required for correctness).
// STRUCTURE
//  - trace_defs.vh: state encodings, SYNC_BYTE default, frame-overhead constant (4).
//  - One sub-module natural: uart_byte_issuer (holds byte, applies issue rule, pulses enable,
//    returns 'accepted'); FSM, address counter and checksum stay in the top of this block.
//  - All state on clk; no second clock; BRAM write side (clk48m) is outside this block.
// TESTING
//  - BRAM model preloaded 0x00..0x37, base=0, len=56, tx_ready always 1 -> bytes A5,38,00,00..37,
//    checksum 0x38^0x00^XOR(0..0x37)=0x38; one done pulse; enable never high two cycles in a row.
//  - len=0 -> exactly A5,00,00,00 then done; no raddr change during frame.
//  - base=510, len=4, data[510]=11,[511]=22,[0]=33,[1]=44 -> payload 11,22,33,44, cksum 04^11^22^33^44=0x40.
//  - tx_ready toggled randomly (1 cycle ready per 10) with RD_LAT=2 -> identical byte stream, no drops.
//  - second start pulsed mid-frame and len=600 -> start ignored; len clamps: LEN_LO=00, LEN_HI=02, 512 payload.
//  - rst low for 1 cycle after 20th byte -> outputs 0 at once; next start sends complete fresh frame.

Source files
------------

// File: rtl/trace_uart_streamer_pkg.sv
// Shared definitions for the trace UART streamer.
//   state_e            : frame FSM states
//   SYNC_BYTE_DEFAULT  : first byte of every frame
//   RD_LAT_MAX         : largest supported BRAM read latency (sizes the wait counter)
package trace_uart_streamer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_CKSUM,
    ST_DONE
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned RD_LAT_MAX        = 2;

endpackage

// File: rtl/trace_uart_streamer_uart_byte_issuer.sv
// Single-byte hand-off to the UART transmitter.
//   clk, rst        : clock, asynchronous active-low reset
//   req, byte_in    : caller presents a byte and holds it until accepted
//   tx_ready        : UART idle
//   tx_enable       : registered one-cycle send strobe
//   tx_data         : registered byte, stable while tx_enable is high
//   accepted        : combinational; the presented byte is taken this cycle
module uart_byte_issuer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] byte_in,
  input  logic       tx_ready,
  output logic       tx_enable,
  output logic [7:0] tx_data,
  output logic       accepted
);

  logic       enable_q, enable_d;
  logic [7:0] data_q, data_d;

  // Gating on our own strobe keeps enable from ever being high two cycles
  // running, even if the UART still reports ready on the strobe cycle.
  always_comb begin
    accepted = req & tx_ready & ~enable_q;
    enable_d = accepted;
    data_d   = accepted ? byte_in : data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q <= 1'b0;
      data_q   <= '0;
    end else begin
      enable_q <= enable_d;
      data_q   <= data_d;
    end
  end

  assign tx_enable = enable_q;
  assign tx_data   = data_q;

endmodule

// File: rtl/trace_uart_streamer.sv
// Drains a trace from the sensor BRAM and sends it over the UART as one frame:
// SYNC, LEN_LO, LEN_HI, payload bytes, XOR checksum (over everything but SYNC).
//   clk, rst          : clock, asynchronous active-low reset
//   start             : one-cycle request, honoured only when idle
//   base_addr         : first BRAM address of the trace (wraps modulo 2^ADDR_W)
//   trace_len         : payload byte count, clamped to 2^ADDR_W
//   raddr / rdata     : BRAM read port, rdata valid RD_LAT cycles after raddr
//   uart_tx_ready     : UART can take a byte
//   uart_tx_enable    : one-cycle send strobe with uart_data_to_tx
//   busy              : frame in progress
//   done              : one-cycle pulse once the checksum has been issued
module trace_uart_streamer
  import trace_uart_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   trace_len,
  output logic [ADDR_W-1:0] raddr,
  input  logic [7:0]        rdata,
  input  logic              uart_tx_ready,
  output logic              uart_tx_enable,
  output logic [7:0]        uart_data_to_tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     LEN_W   = ADDR_W + 1;
  localparam int unsigned     WAIT_W  = $clog2(RD_LAT_MAX + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  idx_inc;
  logic [7:0]        cksum_q, cksum_d;
  logic [7:0]        data_q, data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              issue_req;
  logic [7:0]        issue_byte;
  logic              issue_acc;

  assign idx_inc = idx_q + LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    cksum_d    = cksum_q;
    data_d     = data_q;
    wait_d     = wait_q;
    raddr_d    = raddr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    issue_req  = 1'b0;
    issue_byte = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = (trace_len > LEN_MAX) ? LEN_MAX : trace_len;
          idx_d   = '0;
          cksum_d = '0;
          busy_d  = 1'b1;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        issue_req  = 1'b1;
        issue_byte = SYNC_BYTE;
        if (issue_acc) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        issue_req  = 1'b1;
        issue_byte = len_q[7:0];
        if (issue_acc) begin
          cksum_d = cksum_q ^ issue_byte;
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        issue_req  = 1'b1;
        issue_byte = 8'(len_q >> 8);
        if (issue_acc) begin
          cksum_d = cksum_q ^ issue_byte;
          state_d = (len_q == '0) ? ST_CKSUM : ST_FETCH;
        end
      end
      ST_FETCH: begin
        raddr_d = base_q + idx_q[ADDR_W-1:0];
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      // raddr becomes visible one cycle after FETCH, so the data lands
      // RD_LAT cycles after that; capture on the last wait cycle.
      ST_WAIT: begin
        if (wait_q == WAIT_W'(RD_LAT)) begin
          data_d  = rdata;
          state_d = ST_SEND;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_SEND: begin
        issue_req  = 1'b1;
        issue_byte = data_q;
        if (issue_acc) begin
          cksum_d = cksum_q ^ data_q;
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? ST_CKSUM : ST_FETCH;
        end
      end
      ST_CKSUM: begin
        issue_req  = 1'b1;
        issue_byte = cksum_q;
        if (issue_acc) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cksum_q <= '0;
      data_q  <= '0;
      wait_q  <= '0;
      raddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cksum_q <= cksum_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
      raddr_q <= raddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_byte_issuer u_issuer (
    .clk       (clk),
    .rst       (rst),
    .req       (issue_req),
    .byte_in   (issue_byte),
    .tx_ready  (uart_tx_ready),
    .tx_enable (uart_tx_enable),
    .tx_data   (uart_data_to_tx),
    .accepted  (issue_acc)
  );

  assign raddr = raddr_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
